// File: rtl/unidade_controle_sequenciador_if.sv
// Control/flag bundle between the memory-game control unit and its datapath.
// The master side is the control unit; the slave side is the datapath.
interface unidade_controle_sequenciador_if;
    logic       jogar;
    logic       jogada;
    logic       igual;
    logic       fim_sequencia;
    logic       fim_rodadas;
    logic       timeout;

    logic       zera_endereco;
    logic       conta_endereco;
    logic       zera_rodada;
    logic       conta_rodada;
    logic       zera_registrador;
    logic       registra_jogada;
    logic       zera_timer;
    logic       conta_timer;
    logic       mostra_leds;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
    logic       db_timeout;
    logic [3:0] db_estado;

    modport master (
        input  jogar, jogada, igual, fim_sequencia, fim_rodadas, timeout,
        output zera_endereco, conta_endereco, zera_rodada, conta_rodada,
               zera_registrador, registra_jogada, zera_timer, conta_timer,
               mostra_leds, pronto, ganhou, perdeu, db_timeout, db_estado
    );

    modport slave (
        output jogar, jogada, igual, fim_sequencia, fim_rodadas, timeout,
        input  zera_endereco, conta_endereco, zera_rodada, conta_rodada,
               zera_registrador, registra_jogada, zera_timer, conta_timer,
               mostra_leds, pronto, ganhou, perdeu, db_timeout, db_estado
    );
endinterface

// File: rtl/unidade_controle_sequenciador.sv
// Moore control unit for the memory game: replays the stored sequence with
// timed LED on/off windows, collects and checks moves, ends in win/lose/timeout.
module unidade_controle_sequenciador #(
    parameter int unsigned T_LED = 1000,
    parameter int unsigned T_GAP = 250,
    parameter int unsigned CNT_W = 12
) (
    input logic                            clock,
    input logic                            reset,
    unidade_controle_sequenciador_if.master bus
);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIA_RODADA  = 4'h2,
        MOSTRA_LED     = 4'h3,
        MOSTRA_APAGADO = 4'h4,
        PROXIMO_MOSTRA = 4'h5,
        LIMPA_RODADA   = 4'h6,
        ESPERA_JOGADA  = 4'h7,
        REGISTRA       = 4'h8,
        COMPARA        = 4'h9,
        PROXIMA_JOGADA = 4'hA,
        FIM_GANHOU     = 4'hB,
        FIM_PERDEU     = 4'hC,
        FIM_TIMEOUT    = 4'hD,
        PROXIMA_RODADA = 4'hE
    } estado_t;

    localparam logic [CNT_W-1:0] LED_ULTIMO = CNT_W'(T_LED - 1);
    localparam logic [CNT_W-1:0] GAP_ULTIMO = CNT_W'(T_GAP - 1);

    if (((64'd1 << CNT_W) <= 64'(T_LED)) || ((64'd1 << CNT_W) <= 64'(T_GAP))) begin : g_cnt_w_check
        $error("CNT_W too narrow for T_LED/T_GAP");
    end

    estado_t          estado;
    estado_t          estado_prox;
    logic [CNT_W-1:0] cnt;
    logic             conta_intervalo;
    logic             led_fim;
    logic             gap_fim;

    assign conta_intervalo = (estado == MOSTRA_LED) || (estado == MOSTRA_APAGADO);
    assign led_fim         = (cnt == LED_ULTIMO);
    assign gap_fim         = (cnt == GAP_ULTIMO);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= estado_prox;
        end
    end

    // Interval counter restarts on every state change so each window starts at 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (estado_prox != estado) begin
            cnt <= '0;
        end else if (conta_intervalo) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        estado_prox = estado;
        unique case (estado)
            INICIAL:        if (bus.jogar) estado_prox = PREPARACAO;
            PREPARACAO:     estado_prox = INICIA_RODADA;
            INICIA_RODADA:  estado_prox = MOSTRA_LED;
            MOSTRA_LED:     if (led_fim) estado_prox = MOSTRA_APAGADO;
            MOSTRA_APAGADO: begin
                if (gap_fim) begin
                    estado_prox = bus.fim_sequencia ? LIMPA_RODADA : PROXIMO_MOSTRA;
                end
            end
            PROXIMO_MOSTRA: estado_prox = MOSTRA_LED;
            LIMPA_RODADA:   estado_prox = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (bus.jogada) begin
                    estado_prox = REGISTRA;
                end else if (bus.timeout) begin
                    estado_prox = FIM_TIMEOUT;
                end
            end
            REGISTRA:       estado_prox = COMPARA;
            COMPARA: begin
                if (!bus.igual) begin
                    estado_prox = FIM_PERDEU;
                end else if (!bus.fim_sequencia) begin
                    estado_prox = PROXIMA_JOGADA;
                end else if (bus.fim_rodadas) begin
                    estado_prox = FIM_GANHOU;
                end else begin
                    estado_prox = PROXIMA_RODADA;
                end
            end
            PROXIMA_JOGADA: estado_prox = ESPERA_JOGADA;
            PROXIMA_RODADA: estado_prox = INICIA_RODADA;
            FIM_GANHOU,
            FIM_PERDEU,
            FIM_TIMEOUT:    if (bus.jogar) estado_prox = PREPARACAO;
            default:        estado_prox = INICIAL;
        endcase
    end

    always_comb begin
        bus.zera_endereco    = 1'b0;
        bus.conta_endereco   = 1'b0;
        bus.zera_rodada      = 1'b0;
        bus.conta_rodada     = 1'b0;
        bus.zera_registrador = 1'b0;
        bus.registra_jogada  = 1'b0;
        bus.zera_timer       = 1'b0;
        bus.conta_timer      = 1'b0;
        bus.mostra_leds      = 1'b0;
        bus.pronto           = 1'b0;
        bus.ganhou           = 1'b0;
        bus.perdeu           = 1'b0;
        bus.db_timeout       = 1'b0;
        unique case (estado)
            PREPARACAO: begin
                bus.zera_endereco    = 1'b1;
                bus.zera_rodada      = 1'b1;
                bus.zera_registrador = 1'b1;
                bus.zera_timer       = 1'b1;
            end
            INICIA_RODADA: begin
                bus.zera_endereco = 1'b1;
                bus.zera_timer    = 1'b1;
            end
            MOSTRA_LED:     bus.mostra_leds = 1'b1;
            PROXIMO_MOSTRA: bus.conta_endereco = 1'b1;
            LIMPA_RODADA: begin
                bus.zera_endereco    = 1'b1;
                bus.zera_timer       = 1'b1;
                bus.zera_registrador = 1'b1;
            end
            ESPERA_JOGADA:  bus.conta_timer = 1'b1;
            REGISTRA:       bus.registra_jogada = 1'b1;
            PROXIMA_JOGADA: begin
                bus.conta_endereco = 1'b1;
                bus.zera_timer     = 1'b1;
            end
            PROXIMA_RODADA: bus.conta_rodada = 1'b1;
            FIM_GANHOU: begin
                bus.pronto = 1'b1;
                bus.ganhou = 1'b1;
            end
            FIM_PERDEU: begin
                bus.pronto = 1'b1;
                bus.perdeu = 1'b1;
            end
            FIM_TIMEOUT: begin
                bus.pronto     = 1'b1;
                bus.perdeu     = 1'b1;
                bus.db_timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_sequenciador.sv
// Directed bench for the memory-game control unit with T_LED=4, T_GAP=2.
module tb_unidade_controle_sequenciador;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int unsigned checks   = 0;
    int unsigned failures = 0;

    unidade_controle_sequenciador_if bus ();

    unidade_controle_sequenciador #(
        .T_LED(4),
        .T_GAP(2),
        .CNT_W(12)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // {zera_end, conta_end, zera_rod, conta_rod, zera_reg, registra, zera_tmr,
    //  conta_tmr, mostra_leds, pronto, ganhou, perdeu, db_timeout}
    logic [12:0] outs;
    assign outs = {bus.zera_endereco, bus.conta_endereco, bus.zera_rodada, bus.conta_rodada,
                   bus.zera_registrador, bus.registra_jogada, bus.zera_timer, bus.conta_timer,
                   bus.mostra_leds, bus.pronto, bus.ganhou, bus.perdeu, bus.db_timeout};

    localparam logic [12:0] O_NONE     = 13'b0_0_0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [12:0] O_PREP     = 13'b1_0_1_0_1_0_1_0_0_0_0_0_0;
    localparam logic [12:0] O_INICIA   = 13'b1_0_0_0_0_0_1_0_0_0_0_0_0;
    localparam logic [12:0] O_LED      = 13'b0_0_0_0_0_0_0_0_1_0_0_0_0;
    localparam logic [12:0] O_PROX_MOS = 13'b0_1_0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [12:0] O_LIMPA    = 13'b1_0_0_0_1_0_1_0_0_0_0_0_0;
    localparam logic [12:0] O_ESPERA   = 13'b0_0_0_0_0_0_0_1_0_0_0_0_0;
    localparam logic [12:0] O_REG      = 13'b0_0_0_0_0_1_0_0_0_0_0_0_0;
    localparam logic [12:0] O_PROX_JOG = 13'b0_1_0_0_0_0_1_0_0_0_0_0_0;
    localparam logic [12:0] O_PROX_ROD = 13'b0_0_0_1_0_0_0_0_0_0_0_0_0;
    localparam logic [12:0] O_GANHOU   = 13'b0_0_0_0_0_0_0_0_0_1_1_0_0;
    localparam logic [12:0] O_PERDEU   = 13'b0_0_0_0_0_0_0_0_0_1_0_1_0;
    localparam logic [12:0] O_TIMEOUT  = 13'b0_0_0_0_0_0_0_0_0_1_0_1_1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        bus.jogar = 1'b0; bus.jogada = 1'b0; bus.igual = 1'b0;
        bus.fim_sequencia = 1'b0; bus.fim_rodadas = 1'b0; bus.timeout = 1'b0;
        #2 reset = 1'b0;
        tick();
        checks++;
        if (bus.db_estado !== 4'h0 || outs !== O_NONE) begin
            $display("FAIL reset_low: estado=%h outs=%b, expected estado=0 outs=%b", bus.db_estado, outs, O_NONE);
            failures++;
        end
        reset = 1'b1;
        tick();
        checks++;
        if (bus.db_estado !== 4'h0 || outs !== O_NONE) begin
            $display("FAIL reset_idle: estado=%h outs=%b, expected estado=0 outs=%b", bus.db_estado, outs, O_NONE);
            failures++;
        end
    endtask

    // From inicial: start, replay one item, land in espera_jogada.
    task automatic test_start_replay();
        logic [3:0]  st [10] = '{4'h1, 4'h2, 4'h3, 4'h3, 4'h3, 4'h3, 4'h4, 4'h4, 4'h6, 4'h7};
        logic [12:0] ou [10] = '{O_PREP, O_INICIA, O_LED, O_LED, O_LED, O_LED, O_NONE, O_NONE, O_LIMPA, O_ESPERA};
        bus.jogar = 1'b1;
        bus.fim_sequencia = 1'b1;
        for (int unsigned i = 0; i < 10; i++) begin
            tick();
            bus.jogar = 1'b0;
            checks++;
            if (bus.db_estado !== st[i] || outs !== ou[i]) begin
                $display("FAIL start_replay[%0d]: estado=%h outs=%b, expected estado=%h outs=%b", i, bus.db_estado, outs, st[i], ou[i]);
                failures++;
            end
        end
    endtask

    task automatic test_round_advance();
        logic [3:0]  st [5] = '{4'h8, 4'h9, 4'hE, 4'h2, 4'h3};
        logic [12:0] ou [5] = '{O_REG, O_NONE, O_PROX_ROD, O_INICIA, O_LED};
        bus.jogada = 1'b1; bus.igual = 1'b1; bus.fim_sequencia = 1'b1; bus.fim_rodadas = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            bus.jogada = 1'b0;
            checks++;
            if (bus.db_estado !== st[i] || outs !== ou[i]) begin
                $display("FAIL round_advance[%0d]: estado=%h outs=%b, expected estado=%h outs=%b", i, bus.db_estado, outs, st[i], ou[i]);
                failures++;
            end
        end
    endtask

    // Round 1: two items, jogar/jogada held during replay must be ignored.
    task automatic test_replay_two_items();
        logic [3:0]  st [14] = '{4'h3, 4'h3, 4'h3, 4'h4, 4'h4, 4'h5, 4'h3, 4'h3, 4'h3, 4'h3, 4'h4, 4'h4, 4'h6, 4'h7};
        logic [12:0] ou [14] = '{O_LED, O_LED, O_LED, O_NONE, O_NONE, O_PROX_MOS, O_LED, O_LED, O_LED, O_LED,
                                 O_NONE, O_NONE, O_LIMPA, O_ESPERA};
        bus.fim_sequencia = 1'b0;
        bus.jogar = 1'b1;
        bus.jogada = 1'b1;
        for (int unsigned i = 0; i < 14; i++) begin
            tick();
            if (i == 6) begin
                bus.fim_sequencia = 1'b1;
                bus.jogar = 1'b0;
                bus.jogada = 1'b0;
            end
            checks++;
            if (bus.db_estado !== st[i] || outs !== ou[i]) begin
                $display("FAIL replay_two[%0d]: estado=%h outs=%b, expected estado=%h outs=%b", i, bus.db_estado, outs, st[i], ou[i]);
                failures++;
            end
        end
    endtask

    task automatic test_next_move();
        logic [3:0]  st [4] = '{4'h8, 4'h9, 4'hA, 4'h7};
        logic [12:0] ou [4] = '{O_REG, O_NONE, O_PROX_JOG, O_ESPERA};
        bus.jogada = 1'b1; bus.igual = 1'b1; bus.fim_sequencia = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            tick();
            bus.jogada = 1'b0;
            checks++;
            if (bus.db_estado !== st[i] || outs !== ou[i]) begin
                $display("FAIL next_move[%0d]: estado=%h outs=%b, expected estado=%h outs=%b", i, bus.db_estado, outs, st[i], ou[i]);
                failures++;
            end
        end
    endtask

    task automatic test_wrong_move();
        bus.jogada = 1'b1; bus.igual = 1'b0; bus.fim_sequencia = 1'b1;
        tick();
        bus.jogada = 1'b0;
        tick();
        for (int unsigned i = 0; i < 21; i++) begin
            tick();
            checks++;
            if (bus.db_estado !== 4'hC || outs !== O_PERDEU) begin
                $display("FAIL wrong_move_hold[%0d]: estado=%h outs=%b, expected estado=c outs=%b", i, bus.db_estado, outs, O_PERDEU);
                failures++;
            end
        end
        bus.jogar = 1'b1;
        tick();
        bus.jogar = 1'b0;
        checks++;
        if (bus.db_estado !== 4'h1 || outs !== O_PREP) begin
            $display("FAIL restart_after_loss: estado=%h outs=%b, expected estado=1 outs=%b", bus.db_estado, outs, O_PREP);
            failures++;
        end
    endtask

    // Enters from preparacao; last move correct on the last round.
    task automatic test_win();
        logic [3:0]  st [5] = '{4'h8, 4'h9, 4'hB, 4'hB, 4'hB};
        logic [12:0] ou [5] = '{O_REG, O_NONE, O_GANHOU, O_GANHOU, O_GANHOU};
        bus.fim_sequencia = 1'b1; bus.igual = 1'b1;
        for (int unsigned i = 0; i < 9; i++) tick();
        checks++;
        if (bus.db_estado !== 4'h7) begin
            $display("FAIL win_reach_wait: estado=%h, expected estado=7", bus.db_estado);
            failures++;
        end
        bus.jogada = 1'b1; bus.fim_rodadas = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            bus.jogada = 1'b0;
            checks++;
            if (bus.db_estado !== st[i] || outs !== ou[i]) begin
                $display("FAIL win[%0d]: estado=%h outs=%b, expected estado=%h outs=%b", i, bus.db_estado, outs, st[i], ou[i]);
                failures++;
            end
        end
        bus.fim_rodadas = 1'b0;
    endtask

    task automatic test_timeout();
        logic [3:0] st [12] = '{4'h1, 4'h2, 4'h3, 4'h3, 4'h3, 4'h3, 4'h4, 4'h4, 4'h6, 4'h7, 4'h7, 4'h7};
        bus.jogar = 1'b1; bus.fim_sequencia = 1'b1;
        for (int unsigned i = 0; i < 12; i++) begin
            tick();
            bus.jogar = 1'b0;
            checks++;
            if (bus.db_estado !== st[i]) begin
                $display("FAIL timeout_path[%0d]: estado=%h, expected estado=%h", i, bus.db_estado, st[i]);
                failures++;
            end
        end
        bus.timeout = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            bus.timeout = 1'b0;
            checks++;
            if (bus.db_estado !== 4'hD || outs !== O_TIMEOUT) begin
                $display("FAIL timeout_end[%0d]: estado=%h outs=%b, expected estado=d outs=%b", i, bus.db_estado, outs, O_TIMEOUT);
                failures++;
            end
        end
    endtask

    task automatic test_jogada_priority();
        logic [3:0] st [4] = '{4'h9, 4'hE, 4'h2, 4'h3};
        bus.jogar = 1'b1; bus.fim_sequencia = 1'b1;
        tick();
        bus.jogar = 1'b0;
        for (int unsigned i = 0; i < 9; i++) tick();
        checks++;
        if (bus.db_estado !== 4'h7) begin
            $display("FAIL prio_reach_wait: estado=%h, expected estado=7", bus.db_estado);
            failures++;
        end
        bus.jogada = 1'b1; bus.timeout = 1'b1;
        tick();
        bus.jogada = 1'b0; bus.timeout = 1'b0;
        checks++;
        if (bus.db_estado !== 4'h8 || outs !== O_REG) begin
            $display("FAIL jogada_over_timeout: estado=%h outs=%b, expected estado=8 outs=%b", bus.db_estado, outs, O_REG);
            failures++;
        end
        bus.igual = 1'b1; bus.fim_rodadas = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.db_estado !== st[i]) begin
                $display("FAIL prio_to_replay[%0d]: estado=%h, expected estado=%h", i, bus.db_estado, st[i]);
                failures++;
            end
        end
    endtask

    // Called while in mostra_led; reset drops between clock edges.
    task automatic test_async_reset();
        checks++;
        if (bus.mostra_leds !== 1'b1) begin
            $display("FAIL async_pre: mostra_leds=%b, expected 1", bus.mostra_leds);
            failures++;
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.db_estado !== 4'h0 || outs !== O_NONE) begin
            $display("FAIL async_reset: estado=%h outs=%b, expected estado=0 outs=%b", bus.db_estado, outs, O_NONE);
            failures++;
        end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (bus.db_estado !== 4'h0 || outs !== O_NONE) begin
            $display("FAIL after_reset: estado=%h outs=%b, expected estado=0 outs=%b", bus.db_estado, outs, O_NONE);
            failures++;
        end
    endtask

    initial begin
        test_reset();
        test_start_replay();
        test_round_advance();
        test_replay_two_items();
        test_next_move();
        test_wrong_move();
        test_win();
        test_timeout();
        test_jogada_priority();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
